// File: rtl/chess_pkg.sv
// Shared piece encoding, colour helpers and controller state type for the move path.
// PROMOTION_EN additionally exposes the queen codes used for pawn promotion.
package chess_pkg;

   localparam logic [3:0] W_PAWN   = 4'd5;
   localparam logic [3:0] B_ROOK   = 4'd6;
   localparam logic [3:0] B_PAWN   = 4'd11;
   localparam logic [3:0] EMPTY_SQ = 4'hF;
`ifdef PROMOTION_EN
   localparam logic [3:0] W_QUEEN  = 4'd3;
   localparam logic [3:0] B_QUEEN  = 4'd9;
`endif

   function automatic logic is_white(input logic [3:0] piece);
      return piece <= W_PAWN;
   endfunction

   function automatic logic is_black(input logic [3:0] piece);
      return (piece >= B_ROOK) && (piece <= B_PAWN);
   endfunction

   typedef enum logic [2:0] {
      IDLE,
      SRC_HELD,
      REQUEST,
      WAIT_RESP,
      COMMIT_DST,
      COMMIT_SRC,
      DONE,
      REJECT
   } ctrl_state_t;

endpackage

// File: rtl/move_request_ctrl.sv
// Turns cursor selections into a validator request and commits accepted moves as two writes.
// Optional macro PROMOTION_EN: pawns reaching the last rank are written as queens.
module move_request_ctrl
   import chess_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter bit WHITE_FIRST    = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [2:0]           cursor_x,
   input  logic [2:0]           cursor_y,
   input  logic                 select_pulse,
   input  logic                 cancel_pulse,
   input  logic [7:0][7:0][3:0] board_in,
   output logic [2:0]           req_old_x,
   output logic [2:0]           req_old_y,
   output logic [2:0]           req_new_x,
   output logic [2:0]           req_new_y,
   output logic [3:0]           req_piece_type,
   output logic                 req_valid,
   input  logic                 val_valid_move,
   input  logic                 val_valid_output,
   output logic                 wr_en,
   output logic [2:0]           wr_x,
   output logic [2:0]           wr_y,
   output logic [3:0]           wr_piece,
   output logic                 src_selected,
   output logic                 side_to_move,
   output logic                 busy,
   output logic                 move_done,
   output logic                 move_rejected
);

   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   ctrl_state_t      state, state_nxt;
   logic [2:0]       src_x, src_y, dst_x, dst_y;
   logic [3:0]       src_piece;
   logic [CNT_W-1:0] wait_cnt;
   logic [3:0]       cur_piece;
   logic             cur_own, at_src;
   logic             latch_src, latch_dst;

`ifdef PROMOTION_EN
   function automatic logic [3:0] promote(input logic [3:0] piece, input logic [2:0] y);
      if (piece == W_PAWN && y == 3'd7) return W_QUEEN;
      if (piece == B_PAWN && y == 3'd0) return B_QUEEN;
      return piece;
   endfunction
`endif

   assign cur_piece = board_in[cursor_y][cursor_x];
   assign cur_own   = side_to_move ? is_white(cur_piece) : is_black(cur_piece);
   assign at_src    = (cursor_x == src_x) && (cursor_y == src_y);

   assign req_old_x      = src_x;
   assign req_old_y      = src_y;
   assign req_new_x      = dst_x;
   assign req_new_y      = dst_y;
   assign req_piece_type = src_piece;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         side_to_move <= WHITE_FIRST;
         src_x        <= '0;
         src_y        <= '0;
         src_piece    <= '0;
         dst_x        <= '0;
         dst_y        <= '0;
         wait_cnt     <= '0;
      end else begin
         state <= state_nxt;
         if (latch_src) begin
            src_x     <= cursor_x;
            src_y     <= cursor_y;
            src_piece <= cur_piece;
         end
         if (latch_dst) begin
            dst_x <= cursor_x;
            dst_y <= cursor_y;
         end
         // counter restarts on every entry to WAIT_RESP
         if (state == REQUEST)
            wait_cnt <= '0;
         else if (state == WAIT_RESP)
            wait_cnt <= wait_cnt + 1'b1;
         if (state == DONE)
            side_to_move <= ~side_to_move;
      end
   end

   always_comb begin
      state_nxt     = state;
      latch_src     = 1'b0;
      latch_dst     = 1'b0;
      req_valid     = 1'b0;
      wr_en         = 1'b0;
      wr_x          = '0;
      wr_y          = '0;
      wr_piece      = '0;
      src_selected  = 1'b0;
      busy          = 1'b0;
      move_done     = 1'b0;
      move_rejected = 1'b0;
      case (state)
         IDLE: begin
            if (select_pulse && cur_own) begin
               latch_src = 1'b1;
               state_nxt = SRC_HELD;
            end
         end
         SRC_HELD: begin
            src_selected = 1'b1;
            if (cancel_pulse) begin
               state_nxt = IDLE;
            end else if (select_pulse) begin
               if (at_src) begin
                  state_nxt = IDLE;
               end else if (cur_own) begin
                  latch_src = 1'b1;
               end else begin
                  latch_dst = 1'b1;
                  state_nxt = REQUEST;
               end
            end
         end
         REQUEST: begin
            src_selected = 1'b1;
            busy         = 1'b1;
            req_valid    = 1'b1;
            state_nxt    = WAIT_RESP;
         end
         WAIT_RESP: begin
            src_selected = 1'b1;
            busy         = 1'b1;
            // a verdict on the final counted cycle still wins over the timeout
            if (val_valid_output)
               state_nxt = val_valid_move ? COMMIT_DST : REJECT;
            else if (wait_cnt == CNT_LAST)
               state_nxt = REJECT;
         end
         COMMIT_DST: begin
            src_selected = 1'b1;
            busy         = 1'b1;
            wr_en        = 1'b1;
            wr_x         = dst_x;
            wr_y         = dst_y;
`ifdef PROMOTION_EN
            wr_piece     = promote(src_piece, dst_y);
`else
            wr_piece     = src_piece;
`endif
            state_nxt    = COMMIT_SRC;
         end
         COMMIT_SRC: begin
            src_selected = 1'b1;
            busy         = 1'b1;
            wr_en        = 1'b1;
            wr_x         = src_x;
            wr_y         = src_y;
            wr_piece     = EMPTY_SQ;
            state_nxt    = DONE;
         end
         DONE: begin
            move_done = 1'b1;
            state_nxt = IDLE;
         end
         REJECT: begin
            move_rejected = 1'b1;
            state_nxt     = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_move_request_ctrl.sv
// Directed bench for move_request_ctrl: a per-cycle expectation timeline built from the
// move rules, checked every cycle, plus literal spot checks on the key scenarios.
module tb_move_request_ctrl;

   localparam int TO   = 16;
   localparam int MAXC = 512;
`ifdef PROMOTION_EN
   localparam bit PROMO = 1'b1;
`else
   localparam bit PROMO = 1'b0;
`endif

   typedef struct packed {
      logic       req_valid, wr_en, done, rej, sel, side, busy, chk_req;
      logic [2:0] ox, oy, nx, ny, wx, wy;
      logic [3:0] pt, wp;
   } exp_t;

   exp_t ex [MAXC];

   logic                 clk = 1'b0;
   logic                 reset;
   logic [2:0]           cursor_x, cursor_y;
   logic                 select_pulse, cancel_pulse;
   logic [7:0][7:0][3:0] board;
   logic [2:0]           req_old_x, req_old_y, req_new_x, req_new_y;
   logic [3:0]           req_piece_type;
   logic                 req_valid;
   logic                 val_valid_move, val_valid_output;
   logic                 wr_en;
   logic [2:0]           wr_x, wr_y;
   logic [3:0]           wr_piece;
   logic                 src_selected, side_to_move, busy, move_done, move_rejected;

   int          tests = 0;
   int          failed = 0;
   int          cyc = 0;
   bit          chk_on = 1'b0;
   bit          m_side;
   logic [9:0]  wlog[$];
   logic [15:0] last_req;
   int          done_cyc, rej_cyc;

   move_request_ctrl #(.TIMEOUT_CYCLES(TO), .WHITE_FIRST(1'b1)) dut (
      .clk(clk), .reset(reset),
      .cursor_x(cursor_x), .cursor_y(cursor_y),
      .select_pulse(select_pulse), .cancel_pulse(cancel_pulse),
      .board_in(board),
      .req_old_x(req_old_x), .req_old_y(req_old_y),
      .req_new_x(req_new_x), .req_new_y(req_new_y),
      .req_piece_type(req_piece_type), .req_valid(req_valid),
      .val_valid_move(val_valid_move), .val_valid_output(val_valid_output),
      .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_piece(wr_piece),
      .src_selected(src_selected), .side_to_move(side_to_move), .busy(busy),
      .move_done(move_done), .move_rejected(move_rejected)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int expv);
      tests++;
      if (act != expv) begin
         failed++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, expv);
      end
   endtask

   function automatic logic [3:0] land(input logic [3:0] p, input logic [2:0] y);
      if (PROMO && p == 4'd5 && y == 3'd7) return 4'd3;
      if (PROMO && p == 4'd11 && y == 3'd0) return 4'd9;
      return p;
   endfunction

   task automatic fill_from(input int c, input bit side, input bit sel_v, input bit zero_req);
      for (int i = c; i < MAXC; i++) begin
         ex[i]         = '0;
         ex[i].side    = side;
         ex[i].sel     = sel_v;
         ex[i].chk_req = zero_req;
      end
   endtask

   always @(negedge clk) begin
      if (chk_on && cyc < MAXC) begin
         chk("req_valid", req_valid, ex[cyc].req_valid);
         chk("wr_en", wr_en, ex[cyc].wr_en);
         chk("move_done", move_done, ex[cyc].done);
         chk("move_rejected", move_rejected, ex[cyc].rej);
         chk("src_selected", src_selected, ex[cyc].sel);
         chk("side_to_move", side_to_move, ex[cyc].side);
         chk("busy", busy, ex[cyc].busy);
         if (ex[cyc].chk_req) begin
            chk("req_old_x", req_old_x, ex[cyc].ox);
            chk("req_old_y", req_old_y, ex[cyc].oy);
            chk("req_new_x", req_new_x, ex[cyc].nx);
            chk("req_new_y", req_new_y, ex[cyc].ny);
            chk("req_piece_type", req_piece_type, ex[cyc].pt);
         end
         if (ex[cyc].wr_en) begin
            chk("wr_x", wr_x, ex[cyc].wx);
            chk("wr_y", wr_y, ex[cyc].wy);
            chk("wr_piece", wr_piece, ex[cyc].wp);
         end
         if (wr_en) wlog.push_back({wr_x, wr_y, wr_piece});
         if (req_valid) last_req = {req_old_x, req_old_y, req_new_x, req_new_y, req_piece_type};
         if (move_done) done_cyc = cyc;
         if (move_rejected) rej_cyc = cyc;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sel(input logic [2:0] x, input logic [2:0] y, input bit cancel, output int c);
      cursor_x     = x;
      cursor_y     = y;
      select_pulse = 1'b1;
      cancel_pulse = cancel;
      c            = cyc;
      step();
      select_pulse = 1'b0;
      cancel_pulse = 1'b0;
   endtask

   task automatic do_reset();
      fill_from(cyc, 1'b1, 1'b0, 1'b1);
      m_side = 1'b1;
      reset  = 1'b1;
      step();
      reset  = 1'b0;
   endtask

   // mode 0 = accepted, 1 = rejected, 2 = no verdict; k = cycles from req_valid to verdict
   task automatic move(input logic [2:0] sx, input logic [2:0] sy, input logic [2:0] dx,
                       input logic [2:0] dy, input int mode, input int k, input bit rst_mid,
                       output int d);
      int c0, v, be;
      logic [3:0] p;
      p = board[sy][sx];
      sel(sx, sy, 1'b0, c0);
      fill_from(c0 + 1, m_side, 1'b1, 1'b0);
      sel(dx, dy, 1'b0, d);
      v  = d + 1 + k;
      be = (mode == 0) ? v + 2 : (mode == 1) ? v : d + 1 + TO;
      fill_from(be + 1, m_side, 1'b0, 1'b0);
      for (int i = d + 1; i <= be + 1; i++) begin
         ex[i].busy    = (i <= be);
         ex[i].sel     = (i <= be);
         ex[i].side    = m_side;
         ex[i].chk_req = 1'b1;
         ex[i].ox = sx; ex[i].oy = sy; ex[i].nx = dx; ex[i].ny = dy; ex[i].pt = p;
      end
      ex[d + 1].req_valid = 1'b1;
      if (mode == 0) begin
         ex[be + 1].done = 1'b1;
         fill_from(be + 2, !m_side, 1'b0, 1'b0);
         ex[v + 1].wr_en = 1'b1; ex[v + 1].wx = dx; ex[v + 1].wy = dy; ex[v + 1].wp = land(p, dy);
         ex[v + 2].wr_en = 1'b1; ex[v + 2].wx = sx; ex[v + 2].wy = sy; ex[v + 2].wp = 4'hF;
      end else begin
         ex[be + 1].rej = 1'b1;
      end
      if (mode < 2) begin
         repeat (k) step();
         val_valid_output = 1'b1;
         val_valid_move   = (mode == 0);
         step();
         val_valid_output = 1'b0;
         val_valid_move   = 1'b0;
         if (rst_mid) begin
            fill_from(cyc + 1, 1'b1, 1'b0, 1'b1);
            m_side = 1'b1;
            #5 reset = 1'b1;
            step();
            reset = 1'b0;
         end else if (mode == 0) begin
            m_side = !m_side;
         end
         repeat (6) step();
      end else begin
         repeat (TO + 4) step();
      end
   endtask

   initial begin
      int c, d;
      reset = 1'b1;
      cursor_x = '0; cursor_y = '0;
      select_pulse = 1'b0; cancel_pulse = 1'b0;
      val_valid_move = 1'b0; val_valid_output = 1'b0;
      for (int y = 0; y < 8; y++)
         for (int x = 0; x < 8; x++)
            board[y][x] = 4'hF;
      board[0][0] = 4'd0;
      board[1][1] = 4'd5;
      board[3][2] = 4'd8;
      board[6][4] = 4'd5;
      board[1][3] = 4'd11;
      m_side = 1'b1;
      fill_from(0, 1'b1, 1'b0, 1'b1);
      chk_on = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      step();

      // opponent piece selected as source, stray verdict strobe while idle
      sel(3'd2, 3'd3, 1'b0, c);
      val_valid_output = 1'b1; val_valid_move = 1'b1;
      step();
      val_valid_output = 1'b0; val_valid_move = 1'b0;
      repeat (2) step();
      chk("t2_src_selected", src_selected, 0);
      chk("t2_busy", busy, 0);

      // white pawn (1,1) -> (1,2), accepted two cycles after req_valid
      wlog.delete(); done_cyc = -1;
      move(3'd1, 3'd1, 3'd1, 3'd2, 0, 2, 1'b0, d);
      chk("t1_req", last_req, {3'd1, 3'd1, 3'd1, 3'd2, 4'd5});
      chk("t1_wr_count", wlog.size(), 2);
      if (wlog.size() >= 2) begin
         chk("t1_wr_dst", wlog[0], {3'd1, 3'd2, 4'd5});
         chk("t1_wr_src", wlog[1], {3'd1, 3'd1, 4'hF});
      end
      chk("t1_side", side_to_move, 0);
      chk("t1_latency", done_cyc - d + 1, 7);

      // rook (0,0) -> (0,5) refused by the validator
      do_reset();
      step();
      wlog.delete(); rej_cyc = -1;
      move(3'd0, 3'd0, 3'd0, 3'd5, 1, 2, 1'b0, d);
      chk("t3_wr_count", wlog.size(), 0);
      chk("t3_rej_cycle", rej_cyc - d, 4);
      chk("t3_side", side_to_move, 1);

      // validator silent: forced rejection
      rej_cyc = -1;
      move(3'd0, 3'd0, 3'd0, 3'd3, 2, 0, 1'b0, d);
      chk("t4_timeout", rej_cyc - (d + 2), TO);
      chk("t4_wr_count", wlog.size(), 0);

      // cancel beats a simultaneous select of a legal destination; reselect deselects
      sel(3'd1, 3'd1, 1'b0, c);
      fill_from(c + 1, m_side, 1'b1, 1'b0);
      sel(3'd1, 3'd2, 1'b1, c);
      fill_from(c + 1, m_side, 1'b0, 1'b0);
      step();
      chk("t5_cancel_sel", src_selected, 0);
      chk("t5_cancel_busy", busy, 0);
      sel(3'd1, 3'd1, 1'b0, c);
      fill_from(c + 1, m_side, 1'b1, 1'b0);
      sel(3'd1, 3'd1, 1'b0, c);
      fill_from(c + 1, m_side, 1'b0, 1'b0);
      step();
      chk("t5_deselect", src_selected, 0);

      // reset lands in COMMIT_DST: second write and side flip never happen
      wlog.delete(); done_cyc = -1;
      move(3'd1, 3'd1, 3'd1, 3'd2, 0, 1, 1'b1, d);
      chk("t5_rst_wr_count", wlog.size(), 1);
      chk("t5_rst_no_done", done_cyc, -1);
      chk("t5_rst_side", side_to_move, 1);
      chk("t5_rst_wr_en", wr_en, 0);

      // relatch source, then pawn promotions for both colours
      sel(3'd0, 3'd0, 1'b0, c);
      fill_from(c + 1, m_side, 1'b1, 1'b0);
      wlog.delete();
      move(3'd4, 3'd6, 3'd4, 3'd7, 0, 1, 1'b0, d);
      if (wlog.size() >= 1)
         chk("t6_white_promo", wlog[0], {3'd4, 3'd7, (PROMO ? 4'd3 : 4'd5)});
      chk("t6_wr_count", wlog.size(), 2);
      chk("t6_side", side_to_move, 0);
      wlog.delete();
      move(3'd3, 3'd1, 3'd3, 3'd0, 0, 1, 1'b0, d);
      if (wlog.size() >= 1)
         chk("t6_black_promo", wlog[0], {3'd3, 3'd0, (PROMO ? 4'd9 : 4'd11)});
      chk("t6_side_back", side_to_move, 1);

      repeat (3) step();
      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
